// File: rtl/tipi_pkg.sv
// tipi_pkg: shared register-select and FSM encodings for the TIPI RPi shift port.
package tipi_pkg;
  typedef enum logic [1:0] {REG_TD = 2'd0, REG_TC = 2'd1, REG_RD = 2'd2, REG_RC = 2'd3} reg_sel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [3:0] FULL_CNT = 4'd8;
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hf) ? c : c + 4'd1;
  endfunction
endpackage

// File: rtl/tipi_rpi_shift_if.sv
// tipi_rpi_shift_if: serial link between the Raspberry Pi and the TIPI shift port.
interface tipi_rpi_shift_if;
  logic       r_sclk;
  logic       r_le;
  logic [1:0] r_reg;
  logic       r_din;
  logic       r_dout;
  modport master (output r_sclk, r_le, r_reg, r_din, input r_dout);
  modport slave  (input r_sclk, r_le, r_reg, r_din, output r_dout);
endinterface

// File: rtl/tipi_sync_edge.sv
// tipi_sync_edge: 2-flop synchronizer plus a history flop giving 1-cycle rise/fall pulses.
module tipi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic m_q, s_q, p_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {m_q, s_q, p_q} <= 3'b000;
    else     {m_q, s_q, p_q} <= {d, m_q, s_q};
  assign rise = s_q & ~p_q;
  assign fall = ~s_q & p_q;
endmodule

// File: rtl/tipi_rpi_shift.sv
// tipi_rpi_shift: RPi-side serial access to the TIPI TD/TC/RD/RC latches, framed by r_le.
module tipi_rpi_shift
  import tipi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ti_d,
  input  logic [7:0]        ti_s,
  tipi_rpi_shift_if.slave   rpi,
  output logic [7:0]        rd_q,
  output logic [7:0]        rc_q,
  output logic              td_new,
  output logic              frame_err
);
  logic [7:0] tid_m_q, tid_s_q, tid_p_q, tis_m_q, tis_s_q;
  logic [1:0] reg_m_q, reg_s_q;
  logic       din_m_q, din_s_q;
  logic       sclk_rise, unused_sclk_fall, le_rise, le_fall;
  state_t     state_q, state_d;
  reg_sel_t   sel_q, sel_d;
  logic [7:0] sr_q, sr_d, rd_d, rc_d, load_val;
  logic [3:0] cnt_q, cnt_d;
  logic       td_new_q, td_new_d, frame_err_q, frame_err_d;
  logic       commit, full, is_wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {tid_m_q, tid_s_q, tid_p_q, tis_m_q, tis_s_q} <= '0;
      {reg_m_q, reg_s_q, din_m_q, din_s_q} <= '0;
    end else begin
      {tid_m_q, tid_s_q, tid_p_q} <= {ti_d, tid_m_q, tid_s_q};
      {tis_m_q, tis_s_q} <= {ti_s, tis_m_q};
      {reg_m_q, reg_s_q} <= {rpi.r_reg, reg_m_q};
      {din_m_q, din_s_q} <= {rpi.r_din, din_m_q};
    end
  tipi_sync_edge u_sclk (.clk(clk), .rst(rst), .d(rpi.r_sclk), .rise(sclk_rise), .fall(unused_sclk_fall));
  tipi_sync_edge u_le   (.clk(clk), .rst(rst), .d(rpi.r_le),   .rise(le_rise),   .fall(le_fall));
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (le_rise ? SHIFT : IDLE) :
              state_q == SHIFT ? (le_fall ? COMMIT : SHIFT) : IDLE;
  assign load_val = reg_s_q == REG_TD ? tid_s_q :
                    reg_s_q == REG_TC ? tis_s_q :
                    reg_s_q == REG_RD ? rd_q : rc_q;
  assign commit = state_q == COMMIT;
  assign full   = cnt_q == FULL_CNT;
  assign is_wr  = sel_q == REG_RD || sel_q == REG_RC;
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (state_q == IDLE && le_rise) begin
      sr_d  = load_val;
      cnt_d = 4'd0;
      sel_d = reg_sel_t'(reg_s_q);
    end
    if (state_q == SHIFT && sclk_rise) begin
      sr_d  = {sr_q[6:0], din_s_q};
      cnt_d = sat_inc(cnt_q);
    end
    rd_d        = commit && sel_q == REG_RD && full ? sr_q : rd_q;
    rc_d        = commit && sel_q == REG_RC && full ? sr_q : rc_q;
    frame_err_d = commit && is_wr && !full ? 1'b1 :
                  commit && sel_q == REG_TC && full ? 1'b0 : frame_err_q;
    // a fresh TI write must never be lost to a coincident RPi acknowledge
    td_new_d    = (tid_s_q != tid_p_q) ||
                  (td_new_q && !(commit && sel_q == REG_TD && cnt_q != 4'd0));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      sel_q       <= REG_TD;
      rd_q        <= '0;
      rc_q        <= '0;
      td_new_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      rc_q        <= rc_d;
      td_new_q    <= td_new_d;
      frame_err_q <= frame_err_d;
    end
  assign rpi.r_dout = sr_q[7];
  assign td_new     = td_new_q;
  assign frame_err  = frame_err_q;
endmodule

// File: doc/tipi_rpi_shift.md
TIPI_RPI_SHIFT -- requirements
Module: tipi_rpi_shift

Interface
REQ-001 SHALL have ports: clk  input  1  50MHz system clock; all state is in this domain.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have ports: ti_d  input  8  TI data latch value (written by TI at 0x5fff), asynchronous to clk.
REQ-004 SHALL have ports: ti_s  input  8  TI control latch value (written by TI at 0x5ffd), asynchronous to clk.
REQ-005 SHALL have ports: r_sclk  input  1  RPi shift clock, asynchronous.
REQ-006 SHALL have ports: r_le  input  1  RPi latch enable, asynchronous; high frames a transfer.
REQ-007 SHALL have ports: r_reg  input  2  RPi register select: 0=TD, 1=TC, 2=RD, 3=RC.
REQ-008 SHALL have ports: r_din  input  1  RPi serial data in, MSB first.
REQ-009 SHALL have ports: r_dout  output  1  serial data to RPi, MSB first.
REQ-010 SHALL have ports: rd_q  output  8  RPi data register driven toward TI (read at 0x5ffb).
REQ-011 SHALL have ports: rc_q  output  8  RPi control register driven toward TI (read at 0x5ff9).
REQ-012 SHALL have ports: td_new  output  1  sticky flag: synchronized ti_d changed since RPi last read TD.
REQ-013 SHALL have ports: frame_err  output  1  sticky flag: a write frame ended with a shift count other than 8.

Function
REQ-014 SHALL pass ti_d, ti_s, r_sclk, r_le, r_reg and r_din each through a 2-flop synchronizer.
REQ-015 SHALL detect rising and falling edges of synchronized r_sclk and r_le against a third flop, giving 1-cycle pulses.
REQ-016 SHALL use FSM states IDLE, SHIFT, COMMIT.
REQ-017 SHALL, in IDLE on r_le rise: load the 8-bit shift register from the selected register (TD=sync ti_d, TC=sync ti_s, RD=rd_q, RC=rc_q), clear the bit counter, latch r_reg into sel_q, and go to SHIFT.
REQ-018 SHALL, in SHIFT on r_sclk rise: shift left, insert sync r_din at bit 0, and increment the 4-bit bit counter, saturating at 15.
REQ-019 SHALL drive r_dout from shift register bit 7 at all times; the first bit is valid 3 clk after the r_le rise.
REQ-020 SHALL, in SHIFT on r_le fall, go to COMMIT; a coincident r_sclk rise in that cycle is applied first.
REQ-021 SHALL, in COMMIT, for sel_q=RD or RC with count==8, write the shift register into rd_q or rc_q; for sel_q=RD or RC with count!=8, leave both unchanged and set frame_err; then return to IDLE (1 cycle).
REQ-022 SHALL, for sel_q=TD with count>=1, clear td_new in COMMIT.
REQ-023 SHALL set td_new in any cycle where the synchronized ti_d differs from its previous-cycle value.
REQ-024 SHALL give set priority over clear when a td_new set and clear fall in the same cycle.
REQ-025 SHALL clear frame_err only on a COMMIT of a TC read with count==8 (RPi status read acknowledges the error).
REQ-026 SHALL ignore r_sclk edges in IDLE and r_le rises in SHIFT.
REQ-027 SHALL never change r_reg selection mid-frame; sel_q governs the whole frame.

Reset
REQ-028 SHALL, on rst, asynchronously set: FSM=IDLE, shift register=0, counter=0, rd_q=0x00, rc_q=0x00, td_new=0, frame_err=0, r_dout=0, all synchronizer flops=0.
REQ-029 SHALL abandon a frame in progress on rst with no write; after rst is released, the first r_le rise starts a new frame.

Structure
REQ-030 SHALL take register-select encodings (TD/TC/RD/RC) and FSM state encodings from the shared package tipi_pkg.
REQ-031 SHALL instantiate the sub-module tipi_sync_edge (2-flop sync plus rise/fall pulse) once per control strobe.

Verification
REQ-032 SHALL cover: ti_d=0xA5 held, read frame on TD with 8 sclk -> r_dout sequence 1,0,1,0,0,1,0,1; td_new 1->0 after COMMIT.
REQ-033 SHALL cover: write frame on RD shifting 0x3C -> rd_q=0x3C one cycle after the r_le fall; rc_q unchanged.
REQ-034 SHALL cover: write frame on RC with 5 sclk -> rc_q unchanged, frame_err=1; then a full TC read -> frame_err=0.
REQ-035 SHALL cover: ti_d change 0x00->0x11 in the same cycle as a TD-read COMMIT -> td_new remains 1.
REQ-036 SHALL cover: rst asserted after 4 sclk of an RD write of 0xFF -> rd_q=0x00 and FSM=IDLE; a subsequent full frame behaves normally.
REQ-037 SHALL cover: r_sclk pulses with r_le low -> no shift; r_dout stable.
